// File: rtl/data_sramlike_wbuf_bridge.sv
// SRAM-style data port to single-outstanding SRAM-like bus bridge.
// Stores post into a small write buffer; loads wait for the buffer to drain.
module data_sramlike_wbuf_bridge #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        cpu_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  output logic        d_stall,
  output logic        wbuf_empty
);
  // state  | meaning
  // IDLE   | no bus transaction outstanding; may request write or read
  // WWAIT  | write address accepted, waiting for data_ok
  // RWAIT  | read address accepted, waiting for data_ok
  // RDONE  | read data captured, waiting for the load to retire

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WWAIT, S_RWAIT, S_RDONE} state_t;
  state_t state, state_nxt;

  logic [31:0]      fifo_addr  [WBUF_DEPTH];
  logic [31:0]      fifo_wdata [WBUF_DEPTH];
  logic [1:0]       fifo_size  [WBUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_taken;
  logic [31:0]      rdata_q;

  logic [1:0]  enc_size;
  logic [1:0]  enc_lane;
  logic [31:0] enc_addr;
  logic        unused_addr_bits;

  logic is_store, is_load, fifo_busy, push, pop, rd_capture;
  logic req_c, wr_c;

  // Bus size and low address bits come from the byte enables, not the CPU address.
  always_comb begin
    enc_size = 2'd2;
    enc_lane = 2'd0;
    case (data_sram_wen)
      4'b0001: begin enc_size = 2'd0; enc_lane = 2'd0; end
      4'b0010: begin enc_size = 2'd0; enc_lane = 2'd1; end
      4'b0100: begin enc_size = 2'd0; enc_lane = 2'd2; end
      4'b1000: begin enc_size = 2'd0; enc_lane = 2'd3; end
      4'b0011: begin enc_size = 2'd1; enc_lane = 2'd0; end
      4'b1100: begin enc_size = 2'd1; enc_lane = 2'd2; end
      default: ;
    endcase
  end

  assign enc_addr         = {data_sram_addr[31:2], enc_lane};
  assign unused_addr_bits = ^data_sram_addr[1:0];

  assign is_store  = data_sram_en & (|data_sram_wen) & ~wr_taken;
  assign is_load   = data_sram_en & (data_sram_wen == 4'b0000);
  assign fifo_busy = (count != '0);

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    rd_capture = 1'b0;
    req_c      = 1'b0;
    wr_c       = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_busy) begin
          req_c = 1'b1;
          wr_c  = 1'b1;
          if (data_addr_ok) begin
            if (data_data_ok) pop = 1'b1;
            else              state_nxt = S_WWAIT;
          end
        end else if (is_load) begin
          req_c = 1'b1;
          if (data_addr_ok) begin
            if (data_data_ok) begin
              rd_capture = 1'b1;
              state_nxt  = S_RDONE;
            end else begin
              state_nxt = S_RWAIT;
            end
          end
        end
      end
      S_WWAIT: begin
        if (data_data_ok) begin
          pop       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RWAIT: begin
        if (data_data_ok) begin
          rd_capture = 1'b1;
          state_nxt  = S_RDONE;
        end
      end
      S_RDONE: begin
        if (!cpu_stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot for a store arriving at a full buffer.
  assign push = is_store & ((count != FULL_CNT) | pop);

  assign d_stall    = ~rst & ((is_store & ~push) | (is_load & (state != S_RDONE)));
  assign data_req   = ~rst & req_c;
  assign data_wr    = ~rst & wr_c;
  assign wbuf_empty = (count == '0) & (state != S_WWAIT);

  always_comb begin
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    data_size  = 2'd0;
    if (data_wr) begin
      data_addr  = fifo_addr[rd_ptr];
      data_wdata = fifo_wdata[rd_ptr];
      data_size  = fifo_size[rd_ptr];
    end else if (data_req) begin
      data_addr  = {data_sram_addr[31:2], 2'b00};
      data_size  = 2'd2;
    end
  end

  assign data_sram_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wr_taken <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Remember a store already pushed while the pipeline is frozen.
      if (push & cpu_stall) wr_taken <= 1'b1;
      else if (!cpu_stall)  wr_taken <= 1'b0;
      if (rd_capture) rdata_q <= data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= enc_addr;
      fifo_wdata[wr_ptr] <= data_sram_wdata;
      fifo_size[wr_ptr]  <= enc_size;
    end
  end

endmodule

// File: tb/tb_data_sramlike_wbuf_bridge.sv
// Randomised self-checking bench for data_sramlike_wbuf_bridge: a word memory
// model predicts load data and the in-order bus write stream.
module tb_data_sramlike_wbuf_bridge;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'd0;
  logic [31:0] data_sram_addr = 32'd0;
  logic [31:0] data_sram_wdata = 32'd0;
  logic [31:0] data_sram_rdata;
  logic        cpu_stall = 1'b0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [31:0] data_rdata = 32'd0;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic        d_stall, wbuf_empty;

  data_sramlike_wbuf_bridge #(.WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .cpu_stall(cpu_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .d_stall(d_stall), .wbuf_empty(wbuf_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } wr_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference memory (CPU view, program order) and the slave's memory
  logic [31:0] mmem [logic [29:0]];
  logic [31:0] smem [logic [29:0]];
  wr_t expq [$];
  wr_t wlog [$];

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mmem.exists(a[31:2]) ? mmem[a[31:2]] : dflt(a[31:2]);
  endfunction

  function automatic logic [31:0] sread(input logic [29:0] w);
    return smem.exists(w) ? smem[w] : dflt(w);
  endfunction

  function automatic wr_t exp_write(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.wdata = d;
    e.size  = 2'd2;
    e.addr  = {a[31:2], 2'b00};
    case (wen)
      4'b0001: begin e.size = 2'd0; e.addr[1:0] = 2'd0; end
      4'b0010: begin e.size = 2'd0; e.addr[1:0] = 2'd1; end
      4'b0100: begin e.size = 2'd0; e.addr[1:0] = 2'd2; end
      4'b1000: begin e.size = 2'd0; e.addr[1:0] = 2'd3; end
      4'b0011: begin e.size = 2'd1; e.addr[1:0] = 2'd0; end
      4'b1100: begin e.size = 2'd1; e.addr[1:0] = 2'd2; end
      default: ;
    endcase
    return e;
  endfunction

  // bus slave: random accept and latency, or manually driven handshakes
  bit          man_mode = 1'b0, man_aok = 1'b0, man_dok = 1'b0;
  logic [31:0] man_rdata = 32'd0;
  bit          hold_aok = 1'b0;
  bit          s_busy = 1'b0, prev_rdreq = 1'b0;
  int          s_lat = 0;
  logic        s_wr = 1'b0;
  logic [31:0] s_addr = 32'd0, s_wdata = 32'd0, s_cur;
  logic [1:0]  s_size = 2'd0;
  logic [3:0]  s_mask;
  int n_dok = 0, n_rd = 0, n_wdone = 0, n_rdreq = 0, rd_req_wdone = -1, rd_dok_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      data_addr_ok = 1'b0; data_data_ok = 1'b0; s_busy = 1'b0; prev_rdreq = 1'b0;
    end else if (man_mode) begin
      data_addr_ok = man_aok; data_data_ok = man_dok; data_rdata = man_rdata;
    end else begin
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      if (data_req && !data_wr && !prev_rdreq) begin n_rdreq++; rd_req_wdone = n_wdone; end
      prev_rdreq = data_req && !data_wr;
      if (s_busy) begin
        if (s_lat == 0) begin data_data_ok = 1'b1; s_busy = 1'b0; end
        else s_lat--;
      end else if (data_req && !hold_aok && $urandom_range(0, 3) != 0) begin
        data_addr_ok = 1'b1;
        s_wr = data_wr; s_addr = data_addr; s_size = data_size; s_wdata = data_wdata;
        if ($urandom_range(0, 1) == 1) data_data_ok = 1'b1;
        else begin s_busy = 1'b1; s_lat = int'($urandom_range(0, 2)); end
      end
      if (data_data_ok) begin
        n_dok++;
        if (s_wr) begin
          case (s_size)
            2'd0:    s_mask = 4'b0001 << s_addr[1:0];
            2'd1:    s_mask = 4'b0011 << s_addr[1:0];
            default: s_mask = 4'b1111;
          endcase
          s_cur = sread(s_addr[31:2]);
          for (int b = 0; b < 4; b++) if (s_mask[b]) s_cur[8*b +: 8] = s_wdata[8*b +: 8];
          smem[s_addr[31:2]] = s_cur;
          wlog.push_back('{addr: s_addr, size: s_size, wdata: s_wdata});
          n_wdone++;
        end else begin
          data_rdata = sread(s_addr[31:2]);
          n_rd++;
          rd_dok_cyc = cyc;
        end
      end
    end
  end

  // One memory-stage access; entered and left at posedge+1.
  task automatic do_access(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d,
                           input int freeze, output int stall_cyc, output logic dok_at_ret,
                           output int ret_cyc);
    bit done = 1'b0;
    logic [3:0] mask;
    logic [31:0] cur;
    data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = a; data_sram_wdata = d;
    stall_cyc = 0; dok_at_ret = 1'b0; ret_cyc = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      cpu_stall = (k < freeze);
      @(negedge clk); #1;
      if (!d_stall && !cpu_stall) begin
        done = 1'b1; dok_at_ret = data_data_ok; ret_cyc = cyc;
        if (wen == 4'b0000) begin
          checks++;
          if (data_sram_rdata !== mread(a))
            $display("FAIL load_data addr=%h: got %h expected %h", a, data_sram_rdata, mread(a));
          if (data_sram_rdata !== mread(a)) errors++;
        end else begin
          case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100: mask = wen;
            default: mask = 4'b1111;
          endcase
          cur = mread(a);
          for (int b = 0; b < 4; b++) if (mask[b]) cur[8*b +: 8] = d[8*b +: 8];
          mmem[a[31:2]] = cur;
          expq.push_back(exp_write(wen, a, d));
        end
      end else if (d_stall) begin
        stall_cyc++;
      end
      @(posedge clk); #1;
    end
    cpu_stall = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h wen=%b: got no retire expected retire", a, wen);
    end
  endtask

  task automatic wait_empty(input string name);
    bit done = 1'b0;
    data_sram_en = 1'b0; data_sram_wen = 4'd0; cpu_stall = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk); #1;
      if (wbuf_empty && !s_busy) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout %s: got wbuf_empty=%b expected 1", name, wbuf_empty);
    end
  endtask

  task automatic compare_write_log(input string name);
    int n;
    checks++;
    if (wlog.size() != expq.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d expected %0d", name, wlog.size(), expq.size());
    end
    n = (wlog.size() < expq.size()) ? wlog.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (wlog[i] !== expq[i]) begin
        errors++;
        $display("FAIL %s_write[%0d]: got addr=%h size=%0d data=%h expected addr=%h size=%0d data=%h",
                 name, i, wlog[i].addr, wlog[i].size, wlog[i].wdata,
                 expq[i].addr, expq[i].size, expq[i].wdata);
      end
    end
    wlog.delete();
    expq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_data_req: got %b expected 0", data_req); end
    checks++; if (data_wr !== 1'b0) begin errors++; $display("FAIL reset_data_wr: got %b expected 0", data_wr); end
    checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL reset_d_stall: got %b expected 0", d_stall); end
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL reset_wbuf_empty: got %b expected 1", wbuf_empty); end
    checks++; if (data_sram_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", data_sram_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_word();
    int sc, rc; logic dk;
    do_access(4'b0100, 32'h0000_1000, 32'h00AB_0000, 0, sc, dk, rc);
    checks++; if (sc != 0) begin errors++; $display("FAIL sb_stall: got %0d expected 0", sc); end
    do_access(4'b1100, 32'h0000_2000, 32'hBEEF_0000, 0, sc, dk, rc);
    wait_empty("sub_word");
    checks++;
    if (wlog.size() < 2 || wlog[0].addr !== 32'h0000_1002 || wlog[0].size !== 2'd0) begin
      errors++; $display("FAIL sb_bus: got n=%0d expected addr=00001002 size=0", wlog.size());
    end
    checks++;
    if (wlog.size() < 2 || wlog[1].addr !== 32'h0000_2002 || wlog[1].size !== 2'd1) begin
      errors++; $display("FAIL sh_bus: got n=%0d expected addr=00002002 size=1", wlog.size());
    end
    compare_write_log("sub_word");
  endtask

  task automatic test_buffer_full();
    int sc, rc, dok0; logic dk;
    hold_aok = 1'b1;
    dok0 = n_dok;
    for (int i = 0; i < DEPTH; i++) begin
      do_access(4'b1111, 32'h0000_5000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 0, sc, dk, rc);
      checks++; if (sc != 0) begin errors++; $display("FAIL fill_stall[%0d]: got %0d expected 0", i, sc); end
    end
    fork
      begin repeat (4) @(posedge clk); hold_aok = 1'b0; end
    join_none
    do_access(4'b1111, 32'h0000_5010, 32'h1111_0004, 0, sc, dk, rc);
    checks++; if (sc < 3) begin errors++; $display("FAIL full_stall: got %0d cycles expected >=3", sc); end
    checks++; if (dk !== 1'b1) begin errors++; $display("FAIL full_retire_dok: got %b expected 1", dk); end
    checks++; if (n_dok - dok0 != 1) begin errors++; $display("FAIL full_first_dok: got %0d expected 1", n_dok - dok0); end
    wait_empty("buffer_full");
    compare_write_log("buffer_full");
  endtask

  task automatic test_load_after_stores();
    int sc, rc, wb, rq; logic dk;
    wb = n_wdone; rq = n_rdreq;
    do_access(4'b1111, 32'h0000_3000, 32'hDEAD_BEEF, 0, sc, dk, rc);
    do_access(4'b1111, 32'h0000_3104, 32'h0BAD_F00D, 0, sc, dk, rc);
    do_access(4'b0000, 32'h0000_3000, 32'd0, 0, sc, dk, rc);
    checks++; if (n_rdreq - rq != 1) begin errors++; $display("FAIL raw_read_reqs: got %0d expected 1", n_rdreq - rq); end
    checks++; if (rd_req_wdone != wb + 2) begin errors++; $display("FAIL raw_order: got %0d writes done expected %0d", rd_req_wdone - wb, 2); end
    checks++; if (data_sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_rdata: got %h expected deadbeef", data_sram_rdata); end
    checks++; if (rc != rd_dok_cyc + 1) begin errors++; $display("FAIL raw_stall_fall: got cycle %0d expected %0d", rc, rd_dok_cyc + 1); end
    wait_empty("load_after_stores");
    compare_write_log("load_after_stores");
  endtask

  task automatic test_freeze();
    int ready = 0, rd0, wd0, sc, rc; logic dk;
    logic [31:0] expd;
    expd = mread(32'h0000_3104);
    rd0 = n_rd;
    data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h0000_3104; cpu_stall = 1'b1;
    for (int k = 0; k < 60 && ready < 3; k++) begin
      @(negedge clk); #1;
      if (!d_stall) begin
        ready++;
        checks++;
        if (data_sram_rdata !== expd) begin errors++; $display("FAIL freeze_hold: got %h expected %h", data_sram_rdata, expd); end
      end
      @(posedge clk); #1;
    end
    if (ready < 3) begin checks++; errors++; $display("FAIL freeze_load_timeout: got %0d ready cycles expected 3", ready); end
    cpu_stall = 1'b0;
    @(negedge clk); #1;
    checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL freeze_load_retire: got %b expected 0", d_stall); end
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (n_rd - rd0 != 1) begin errors++; $display("FAIL freeze_read_count: got %0d expected 1", n_rd - rd0); end
    wd0 = n_wdone;
    do_access(4'b1111, 32'h0000_3108, 32'hC0DE_0001, 3, sc, dk, rc);
    wait_empty("freeze");
    checks++; if (n_wdone - wd0 != 1) begin errors++; $display("FAIL freeze_push_count: got %0d expected 1", n_wdone - wd0); end
    compare_write_log("freeze");
  endtask

  task automatic test_random();
    logic [3:0] st_wens [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                                 4'b1100, 4'b1111, 4'b0111, 4'b0110, 4'b1110};
    int sc, rc, fz; logic dk;
    logic [3:0] wen;
    logic [31:0] a;
    for (int i = 0; i < 100; i++) begin
      a = 32'h0000_4000 + 32'($urandom_range(0, 15)) * 32'd4;
      if ($urandom_range(0, 9) < 3) begin
        wen = 4'b0000;
      end else begin
        wen = st_wens[$urandom_range(0, 9)];
        a[1:0] = 2'($urandom_range(0, 3));
      end
      fz = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_access(wen, a, $urandom, fz, sc, dk, rc);
      if ($urandom_range(0, 3) == 0) begin
        data_sram_en = 1'b0;
        @(posedge clk); #1;
      end
    end
    wait_empty("random");
    compare_write_log("random");
  endtask

  task automatic test_reset_mid_read();
    man_mode = 1'b1; man_aok = 1'b1; man_dok = 1'b0; man_rdata = 32'd0;
    data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h0000_6000; cpu_stall = 1'b0;
    @(negedge clk); #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL midrd_req: got %b expected 1", data_req); end
    @(posedge clk); #1;
    man_aok = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; data_sram_en = 1'b0; man_dok = 1'b1; man_rdata = 32'h1234_5678;
    @(negedge clk); #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL midrd_req_after: got %b expected 0", data_req); end
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL midrd_empty: got %b expected 1", wbuf_empty); end
    @(posedge clk); #1;
    man_dok = 1'b0;
    @(negedge clk); #1;
    checks++; if (data_sram_rdata !== 32'd0) begin errors++; $display("FAIL midrd_stray_dok: got %h expected 0", data_sram_rdata); end
    checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL midrd_d_stall: got %b expected 0", d_stall); end
    @(posedge clk); #1;
    data_sram_en = 1'b1; man_aok = 1'b1; man_dok = 1'b1; man_rdata = 32'hCAFE_F00D;
    @(negedge clk); #1;
    checks++; if (data_req !== 1'b1 || d_stall !== 1'b1) begin errors++; $display("FAIL midrd_idle: got req=%b stall=%b expected 1 1", data_req, d_stall); end
    @(posedge clk); #1;
    man_aok = 1'b0; man_dok = 1'b0;
    @(negedge clk); #1;
    checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL midrd_min_stall: got %b expected 0", d_stall); end
    checks++; if (data_sram_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL midrd_rdata: got %h expected cafef00d", data_sram_rdata); end
    @(posedge clk); #1;
    data_sram_en = 1'b0; man_mode = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sub_word();
    test_buffer_full();
    test_load_after_stores();
    test_freeze();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
